// File: rtl/crossing_arb_pkg.sv
// Shared types and helpers for the crossing-register arbiter.
package crossing_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so derived vectors always have a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick
    import crossing_arb_pkg::*;
#(
    parameter int unsigned nreq = 4,
    parameter int unsigned PW   = clog2(nreq)
) (
    input  logic [nreq-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [nreq-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic        w_found;
    int unsigned w_j;

    // Scan upward from ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < int'(nreq); k++) begin
            w_j = (int'(ptr) + k) % nreq;
            if (!w_found && req[w_j]) begin
                w_found  = 1'b1;
                gnt[w_j] = 1'b1;
                idx      = PW'(w_j);
            end
        end
    end

endmodule

// File: rtl/crossing_reg_arbiter.sv
// Round-robin arbiter that sequences single-cycle writes into a crossing
// register, followed by a fixed hold window so the far side samples stable data.
module crossing_reg_arbiter
    import crossing_arb_pkg::*;
#(
    parameter int unsigned     width = 8,
    parameter int unsigned     nreq  = 4,
    parameter int unsigned     hold  = 4,
    parameter logic [width-1:0] init = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [nreq-1:0]       REQ,
    input  logic [nreq*width-1:0] DATA_IN,
    output logic [nreq-1:0]       GNT,
    output logic                  EN_OUT,
    output logic [width-1:0]      D_OUT,
    output logic                  BUSY
);

    localparam int unsigned PW = clog2(nreq);
    localparam int unsigned CW = clog2(hold + 1);

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr,   w_ptr_nxt;
    logic [CW-1:0]    r_cnt,   w_cnt_nxt;
    logic [nreq-1:0]  r_gnt,   w_gnt_nxt;
    logic             r_en,    w_en_nxt;
    logic [width-1:0] r_dout,  w_dout_nxt;

    logic [nreq-1:0]  w_pick_gnt;
    logic [PW-1:0]    w_pick_idx;

    rr_pick #(
        .nreq (nreq),
        .PW   (PW)
    ) u_pick (
        .req  (REQ),
        .ptr  (r_ptr),
        .gnt  (w_pick_gnt),
        .idx  (w_pick_idx)
    );

    // State and output registers; reset abandons any in-flight grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_en    <= 1'b0;
            r_dout  <= init;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_en    <= w_en_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, one WRITE cycle, then hold cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = '0;
        w_en_nxt    = 1'b0;
        w_dout_nxt  = r_dout;
        unique case (r_state)
            IDLE: begin
                if (|REQ) begin
                    w_state_nxt = WRITE;
                    w_gnt_nxt   = w_pick_gnt;
                    w_en_nxt    = 1'b1;
                    w_dout_nxt  = DATA_IN[int'(w_pick_idx)*width +: width];
                    w_ptr_nxt   = (w_pick_idx == PW'(nreq - 1)) ? '0 : w_pick_idx + PW'(1);
                end
            end
            WRITE: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = '0;
            end
            HOLD: begin
                if (r_cnt == CW'(hold - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign GNT    = r_gnt;
    assign EN_OUT = r_en;
    assign D_OUT  = r_dout;
    assign BUSY   = (r_state != IDLE);

endmodule

// File: tb/tb_crossing_reg_arbiter.sv
// Self-checking bench: table vectors, scoreboard of expected writes, corner sequences.
module tb_crossing_reg_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: width 8, nreq 4, hold 4.
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        en;
    logic [7:0]  dout;
    logic        busy;

    // Second instance: nreq 2, hold 1.
    logic        rst2;
    logic [1:0]  req2;
    logic [15:0] data2;
    logic [1:0]  gnt2;
    logic        en2;
    logic [7:0]  dout2;
    logic        busy2;

    crossing_reg_arbiter #(
        .width (8),
        .nreq  (4),
        .hold  (4),
        .init  (8'h00)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .DATA_IN (data),
        .GNT     (gnt),
        .EN_OUT  (en),
        .D_OUT   (dout),
        .BUSY    (busy)
    );

    crossing_reg_arbiter #(
        .width (8),
        .nreq  (2),
        .hold  (1),
        .init  (8'h00)
    ) dut2 (
        .CLK     (clk),
        .RST     (rst2),
        .REQ     (req2),
        .DATA_IN (data2),
        .GNT     (gnt2),
        .EN_OUT  (en2),
        .D_OUT   (dout2),
        .BUSY    (busy2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] dout;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic [7:0] exp_dout;
    } vec_t;

    logic prev_en  = 1'b0;
    logic prev_en2 = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: each write pops one expected {grant, data}.
    always @(negedge clk) begin
        if (en) begin
            check("sb_nonempty", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("sb_gnt", gnt, mon_e.gnt);
                check("sb_dout", dout, mon_e.dout);
            end
            check("en_back_to_back", prev_en, 0);
        end
        if (en2) begin
            check("en2_back_to_back", prev_en2, 0);
        end
        prev_en  <= en;
        prev_en2 <= en2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Advance until the selected instance writes; a timeout counts as a failure.
    task automatic wait_en(input bit sel, input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel ? en2 : en) == 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check("wait_en_timeout", sel ? en2 : en, 1);
    endtask

    vec_t vecs[6];
    exp_t rr_exp[5];
    int   c, last;
    logic [1:0] exp2;

    initial begin
        rst   = 1'b1;
        rst2  = 1'b1;
        req   = '0;
        req2  = '0;
        data  = {8'hD4, 8'hA5, 8'hB2, 8'hC1};
        data2 = {8'h5B, 8'h5A};

        vecs[0] = '{4'b0100, 4'b0100, 8'hA5};
        vecs[1] = '{4'b1111, 4'b0001, 8'hC1};
        vecs[2] = '{4'b1010, 4'b0010, 8'hB2};
        vecs[3] = '{4'b1000, 4'b1000, 8'hD4};
        vecs[4] = '{4'b0110, 4'b0010, 8'hB2};
        vecs[5] = '{4'b1100, 4'b0100, 8'hA5};

        // Table vectors: reset, single arbitration, then the busy window.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            check("rst_gnt", gnt, 0);
            check("rst_en", en, 0);
            check("rst_busy", busy, 0);
            check("rst_dout", dout, 8'h00);
            req = vecs[v].req;
            sb_q.push_back('{vecs[v].exp_gnt, vecs[v].exp_dout});
            tick();
            check("vec_gnt", gnt, vecs[v].exp_gnt);
            check("vec_en", en, 1);
            check("vec_dout", dout, vecs[v].exp_dout);
            check("vec_busy_write", busy, 1);
            req = '0;
            for (int k = 0; k < 4; k++) begin
                tick();
                check("vec_busy_hold", {busy, en}, 2'b10);
            end
            tick();
            check("vec_idle_busy", busy, 0);
            check("vec_dout_held", dout, vecs[v].exp_dout);
        end

        // All four requesting continuously: 0,1,2,3,0 spaced 6 cycles apart.
        do_reset();
        rr_exp[0] = '{4'b0001, 8'hC1};
        rr_exp[1] = '{4'b0010, 8'hB2};
        rr_exp[2] = '{4'b0100, 8'hA5};
        rr_exp[3] = '{4'b1000, 8'hD4};
        rr_exp[4] = '{4'b0001, 8'hC1};
        for (int i = 0; i < 5; i++) sb_q.push_back(rr_exp[i]);
        req  = 4'b1111;
        last = -1;
        for (int i = 0; i < 5; i++) begin
            wait_en(1'b0, 20, c);
            if (i > 0) check("rr_spacing", c - last, 6);
            last = c;
        end
        req = '0;
        repeat (6) tick();

        // Request arriving during HOLD waits for IDLE.
        do_reset();
        req = 4'b0001;
        sb_q.push_back('{4'b0001, 8'hC1});
        tick();
        check("hold_first_gnt", gnt, 4'b0001);
        req = '0;
        tick();
        tick();
        req = 4'b0010;
        sb_q.push_back('{4'b0010, 8'hB2});
        tick();
        check("hold_no_gnt_a", {gnt, en}, 0);
        tick();
        check("hold_no_gnt_b", {gnt, en}, 0);
        check("hold_busy", busy, 1);
        tick();
        check("hold_idle", {busy, gnt}, 0);
        tick();
        check("hold_late_gnt", gnt, 4'b0010);
        check("hold_late_en", en, 1);
        req = '0;
        repeat (6) tick();

        // Reset in the 2nd HOLD cycle clears everything including ptr.
        do_reset();
        req = 4'b0100;
        sb_q.push_back('{4'b0100, 8'hA5});
        tick();
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        req = 4'b1010;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_gnt", gnt, 0);
        check("midrst_en", en, 0);
        check("midrst_dout", dout, 8'h00);
        sb_q.push_back('{4'b0010, 8'hB2});
        tick();
        check("midrst_ptr_gnt", gnt, 4'b0010);
        check("midrst_ptr_dout", dout, 8'hB2);
        req = '0;
        repeat (6) tick();

        // Quiet period: no writes, D_OUT holds.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("quiet_en_gnt", {gnt, en}, 0);
            check("quiet_dout", dout, 8'hB2);
        end

        // hold=1, nreq=2, both requesting: alternate every 3 cycles.
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check("i2_rst", {gnt2, en2, busy2, dout2}, 0);
        req2 = 2'b11;
        last = -1;
        exp2 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            wait_en(1'b1, 10, c);
            check("i2_gnt", gnt2, exp2);
            check("i2_dout", dout2, (exp2 == 2'b01) ? 8'h5A : 8'h5B);
            if (i > 0) check("i2_spacing", c - last, 3);
            last = c;
            exp2 = {exp2[0], exp2[1]};
        end
        req2 = '0;
        repeat (4) tick();

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crossing_reg_arbiter.md
# crossing_reg_arbiter

Round-robin arbiter and update sequencer for a shared crossing register. Up to `nreq` same-clock requesters each present a value. The block grants one requester at a time and drives a single-cycle `EN_OUT` with the selected data to the crossing register's `D_IN`/`EN`. After each write it enforces a minimum hold window so the receiving domain always samples a stable value. It sits between the requesting control logic and the crossing register instance.

## Interface
- `width`, 8: data width of the crossing register.
- `nreq`, 4: number of requesters. Legal range is 2..16.
- `hold`, 4: number of stable cycles enforced after each write. Must be ≥1.
- `init`, all zeros: reset value of `D_OUT`. Must equal the crossing register's `init`.

Ports:
- `CLK`  in  1  clock. Single clock domain.
- `RST`  in  1  reset, synchronous and active-high.
- `REQ`  in  nreq  per-requester request level. Held high until granted.
- `DATA_IN`  in  nreq*width  requester i's data at bits [i*width +: width]. Must be stable while `REQ[i]` is high.
- `GNT`  out  nreq  one-hot grant pulse, one cycle.
- `EN_OUT`  out  1  write enable to the crossing register.
- `D_OUT`  out  width  data to the crossing register. Holds the last written value.
- `BUSY`  out  1  high in WRITE and HOLD.

## Operation
- Clock and reset: one clock (`CLK`). Reset is synchronous and active-high (`RST`).
- FSM states:
  - IDLE: arbitrate.
  - WRITE: one cycle. `EN_OUT`=1 and `GNT` is one-hot.
  - HOLD: counts `hold` cycles.
- Transitions:
  - IDLE → WRITE when `REQ`≠0. Otherwise stay in IDLE.
  - WRITE → HOLD unconditionally.
  - HOLD → IDLE when the hold counter reaches `hold`-1.
- Arbitration (at the IDLE clock edge):
  - Winner is the first asserted `REQ` bit scanning upward from `ptr`, wrapping at `nreq`-1 → 0.
  - `D_OUT` ← winner's `DATA_IN` slice.
  - `GNT` ← one-hot(winner), registered, so it is visible during WRITE.
  - `ptr` ← (winner+1) mod `nreq`.
- `REQ` is ignored outside IDLE. Requests arriving during WRITE/HOLD wait; nothing is lost because requests are levels.
- The granted requester must deassert `REQ` on the cycle after `GNT`. If it is still high at the next IDLE, it is treated as a new request.
- `D_OUT` changes only on the IDLE→WRITE edge and is constant at all other times.
- Hold counter width is $clog2(hold+1). It is cleared on entry to HOLD.

## Timing
- Reset values:
  - state = IDLE
  - `GNT`=0, `EN_OUT`=0, `BUSY`=0
  - `D_OUT`=`init`
  - `ptr`=0, so requester 0 has highest priority after reset
  - hold counter = 0
- Latency: `REQ` high at edge t in IDLE → `GNT`/`EN_OUT` high during cycle t+1. The crossing register captures at edge t+2.
- Minimum update period is `hold`+2 cycles (WRITE + `hold` + IDLE).
- Simultaneous requests: exactly one grant, chosen by round-robin. No requester starves; the worst-case wait is (`nreq`-1)·(`hold`+2) cycles after its request.
- Reset mid-WRITE or mid-HOLD: the next cycle is IDLE with all reset values and the in-flight grant is abandoned. `D_OUT` returns to `init`, matching the crossing register's own reset.
- `hold`=1: HOLD lasts exactly one cycle.

## Structure
- Package `crossing_arb_pkg`:
  - state enum {IDLE, WRITE, HOLD}
  - function `clog2` used for the pointer and counter widths
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req[nreq]`, `ptr`.
  - Outputs: one-hot `gnt` and index `idx`.
  - Reusable by other arbiters in the codebase.
- The top level holds the FSM, `ptr`, the hold counter and the output registers.

## Test plan
- Reset then `REQ`=4'b0100, `DATA_IN[2]`=8'hA5 → `GNT`=4'b0100 and `EN_OUT`=1 one cycle later. `D_OUT`=8'hA5 thereafter. `BUSY` stays high for 5 cycles (WRITE + 4 HOLD).
- `REQ`=4'b1111 held continuously with requesters re-asserting → grant order 0,1,2,3,0. Grants are spaced exactly 6 cycles apart.
- `REQ[1]` rises during HOLD of a grant to requester 0 → no grant until IDLE. `GNT`=4'b0010 arrives on the cycle after IDLE.
- `RST` asserted in the 2nd HOLD cycle → next cycle state is IDLE and `D_OUT`=`init`. A pending `REQ[3]` is granted first only if no lower index is requesting (`ptr`=0).
- No requests for 20 cycles → `EN_OUT`=0 and `GNT`=0 throughout. `D_OUT` is unchanged.
- `hold`=1, `nreq`=2, both requesting → grants alternate every 3 cycles. `EN_OUT` is never high in two consecutive cycles.
